l1a_check_sequencer: RTL and testbench

Sequences L1A data-integrity checks across the ADC readout chain. Accepts L1A trigger pulses, queues them as a pending count, and issues one `need_check` pulse per trigger to the downstream L1A checker. It then tracks per-ADC completion as a one-hot walk and enforces a per-check timeout. It also keeps sticky error flags and counters, so that a check never overlaps a previous unfinished one.

---
 rtl/l1a_pkg.sv | 15 +
 rtl/l1a_check_sequencer_sat_counter.sv | 34 +++
 rtl/l1a_check_sequencer.sv | 166 ++++++++++++++++
 tb/tb_l1a_check_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/l1a_pkg.sv
// l1a_pkg: shared definitions for the L1A check sequencer.
//   state_e   - sequencer FSM states
//   ERR_CNT_W - width of the saturating error-event counter
package l1a_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/l1a_check_sequencer_sat_counter.sv
// sat_counter: W-bit up-counter, adds 0/1/2 per cycle and sticks at all-ones.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear; a same-cycle increment is still applied
//   inc        : increment amount (0..2)
//   count      : registered count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [1:0]   inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;
   logic [W-1:0] base;
   logic [W:0]   sum;

   always_comb begin
      base    = clr ? '0 : count_q;
      // one extra bit catches the wrap; W+1 bits always hold base+2
      sum     = {1'b0, base} + (W+1)'(inc);
      count_d = sum[W] ? '1 : sum[W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/l1a_check_sequencer.sv
// l1a_check_sequencer: queues L1A triggers and runs one integrity check per
// trigger, walking a one-hot ADC pointer and aborting on timeout.
//   clk, reset        : clock, async active-low reset
//   l1a_trig          : request one more check
//   adc_finish        : current ADC finished its check
//   err_clear         : clear sticky error flags and err_count
//   need_check        : one-cycle start pulse to the checker
//   active_adc        : one-hot ADC under check, 0 when none
//   busy              : FSM not idle
//   pending           : queued checks including the one in flight
//   done              : one-cycle pulse when the last ADC finishes
//   overflow_err, timeout_err, protocol_err : sticky error flags
//   err_count, check_count : saturating event counters
module l1a_check_sequencer
   import l1a_pkg::*;
#(
   parameter int N_ADC   = 2,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       l1a_trig,
   input  logic                       adc_finish,
   input  logic                       err_clear,
   output logic                       need_check,
   output logic [N_ADC-1:0]           active_adc,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       done,
   output logic                       overflow_err,
   output logic                       timeout_err,
   output logic                       protocol_err,
   output logic [ERR_CNT_W-1:0]       err_count,
   output logic [CNT_W-1:0]           check_count
);

   localparam int PW = $clog2(DEPTH+1);
   localparam int TW = $clog2(TIMEOUT+1);
   localparam logic [PW-1:0] DEPTH_V   = PW'(DEPTH);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

   state_e           state_q, state_d;
   logic [PW-1:0]    pend_q, pend_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [N_ADC-1:0] active_q, active_d;
   logic             need_q, need_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             to_q, to_d;
   logic             proto_q, proto_d;

   logic             fin_last, to_ev, proto_ev, ovf_ev, dec;
   logic [1:0]       err_inc;

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      active_d = active_q;
      need_d   = 1'b0;
      done_d   = 1'b0;
      fin_last = 1'b0;
      to_ev    = 1'b0;

      case (state_q)
         // outputs are registered, so the start pulse and first ADC are
         // loaded on the IDLE->ISSUE edge to appear during ISSUE
         ST_IDLE: begin
            if (pend_q != '0) begin
               state_d  = ST_ISSUE;
               need_d   = 1'b1;
               active_d = N_ADC'(1);
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            timer_d = timer_q + TW'(1);
            // a finish on the timeout cycle wins over the abort
            if (adc_finish) begin
               if (active_q[N_ADC-1]) begin
                  fin_last = 1'b1;
                  done_d   = 1'b1;
                  active_d = '0;
                  state_d  = ST_GAP;
               end else begin
                  active_d = active_q << 1;
               end
            end else if (timer_q == TIMEOUT_V) begin
               to_ev    = 1'b1;
               active_d = '0;
               state_d  = ST_GAP;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      proto_ev = adc_finish && (state_q != ST_WAIT);
      dec      = fin_last | to_ev;
      ovf_ev   = l1a_trig && !dec && (pend_q == DEPTH_V);

      pend_d = pend_q;
      if (l1a_trig && !dec && !ovf_ev) pend_d = pend_q + PW'(1);
      else if (dec && !l1a_trig)       pend_d = pend_q - PW'(1);

      // new events beat a same-cycle clear
      ovf_d   = (ovf_q   & ~err_clear) | ovf_ev;
      to_d    = (to_q    & ~err_clear) | to_ev;
      proto_d = (proto_q & ~err_clear) | proto_ev;
      // timeout only in WAIT, protocol only outside it: sum never exceeds 2
      err_inc = {1'b0, ovf_ev} + {1'b0, to_ev} + {1'b0, proto_ev};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         pend_q   <= '0;
         timer_q  <= '0;
         active_q <= '0;
         need_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         to_q     <= 1'b0;
         proto_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         timer_q  <= timer_d;
         active_q <= active_d;
         need_q   <= need_d;
         done_q   <= done_d;
         ovf_q    <= ovf_d;
         to_q     <= to_d;
         proto_q  <= proto_d;
      end
   end

   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (err_clear),
      .inc   (err_inc),
      .count (err_count)
   );

   sat_counter #(.W(CNT_W)) u_chk_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (1'b0),
      .inc   ({1'b0, fin_last}),
      .count (check_count)
   );

   assign need_check   = need_q;
   assign active_adc   = active_q;
   assign busy         = (state_q != ST_IDLE);
   assign pending      = pend_q;
   assign done         = done_q;
   assign overflow_err = ovf_q;
   assign timeout_err  = to_q;
   assign protocol_err = proto_q;

endmodule

// File: tb/tb_l1a_check_sequencer.sv
// Directed bench for l1a_check_sequencer (N_ADC=2, DEPTH=4, TIMEOUT=10).
module tb_l1a_check_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        l1a_trig = 1'b0;
   logic        adc_finish = 1'b0;
   logic        err_clear = 1'b0;
   logic        need_check, busy, done;
   logic [1:0]  active_adc;
   logic [2:0]  pending;
   logic        overflow_err, timeout_err, protocol_err;
   logic [7:0]  err_count;
   logic [15:0] check_count;

   int total = 0;
   int bad   = 0;
   int cyc = 0, nc_cnt = 0, nc_last = -1, min_gap = 1000, order_viol = 0;
   bit done_since = 1'b1;
   int nc_snap;

   l1a_check_sequencer #(.N_ADC(2), .DEPTH(4), .TIMEOUT(10), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .l1a_trig     (l1a_trig),
      .adc_finish   (adc_finish),
      .err_clear    (err_clear),
      .need_check   (need_check),
      .active_adc   (active_adc),
      .busy         (busy),
      .pending      (pending),
      .done         (done),
      .overflow_err (overflow_err),
      .timeout_err  (timeout_err),
      .protocol_err (protocol_err),
      .err_count    (err_count),
      .check_count  (check_count)
   );

   always #5 clk = ~clk;

   // start-pulse spacing and ordering against done
   always @(negedge clk) begin
      cyc++;
      if (need_check) begin
         nc_cnt++;
         if (nc_last >= 0 && (cyc - nc_last) < min_gap) min_gap = cyc - nc_last;
         if (!done_since) order_viol++;
         done_since = 1'b0;
         nc_last = cyc;
      end
      if (done) done_since = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_in_wait(input string tag);
      int n = 0;
      while (!(active_adc == 2'b01 && !need_check && busy) && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_reach_wait"}, 32'(n < 20), 1);
   endtask

   task automatic run_one(input string tag);
      wait_in_wait(tag);
      adc_finish = 1'b1;
      tick();
      chk({tag, "_shift"}, 32'(active_adc), 2);
      tick();
      adc_finish = 1'b0;
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_act0"}, 32'(active_adc), 0);
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pend", 32'(pending), 0);
      chk("rst_need", 32'(need_check), 0);
      chk("rst_act", 32'(active_adc), 0);
      chk("rst_flags", 32'({overflow_err, timeout_err, protocol_err, done}), 0);
      chk("rst_cnts", 32'({err_count, check_count}), 0);
      reset = 1'b1;
      tick();

      // single check
      l1a_trig = 1'b1; tick(); l1a_trig = 1'b0;
      chk("t1_pend1", 32'(pending), 1);
      chk("t1_need_early", 32'(need_check), 0);
      tick();
      chk("t1_need", 32'(need_check), 1);
      chk("t1_act_issue", 32'(active_adc), 1);
      chk("t1_busy", 32'(busy), 1);
      tick();
      chk("t1_need_off", 32'(need_check), 0);
      adc_finish = 1'b1; tick();
      chk("t1_act_shift", 32'(active_adc), 2);
      chk("t1_no_done", 32'(done), 0);
      tick(); adc_finish = 1'b0;
      chk("t1_done", 32'(done), 1);
      chk("t1_act0", 32'(active_adc), 0);
      chk("t1_ccnt", 32'(check_count), 1);
      chk("t1_pend0", 32'(pending), 0);
      chk("t1_gap_busy", 32'(busy), 1);
      tick();
      chk("t1_done_off", 32'(done), 0);
      chk("t1_idle", 32'(busy), 0);
      chk("t1_noerr", 32'({overflow_err, timeout_err, protocol_err, err_count}), 0);

      // burst with overflow
      l1a_trig = 1'b1; repeat (4) tick();
      chk("b_pend4", 32'(pending), 4);
      chk("b_no_ovf", 32'(overflow_err), 0);
      tick(); l1a_trig = 1'b0;
      chk("b_pend_full", 32'(pending), 4);
      chk("b_ovf", 32'(overflow_err), 1);
      chk("b_errcnt", 32'(err_count), 1);
      repeat (4) run_one("burst");
      tick();
      chk("b_pend0", 32'(pending), 0);
      chk("b_ccnt", 32'(check_count), 5);
      chk("b_idle", 32'(busy), 0);
      chk("b_nc_cnt", 32'(nc_cnt), 5);
      chk("b_gap", 32'(min_gap >= 3), 1);
      chk("b_order", 32'(order_viol), 0);

      // error clearing and stray finish
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      chk("c_ovf_clr", 32'(overflow_err), 0);
      chk("c_cnt_clr", 32'(err_count), 0);
      chk("c_ccnt_kept", 32'(check_count), 5);
      adc_finish = 1'b1; tick(); adc_finish = 1'b0;
      chk("s_proto", 32'(protocol_err), 1);
      chk("s_errcnt", 32'(err_count), 1);
      chk("s_idle", 32'({busy, pending}), 0);
      err_clear = 1'b1; adc_finish = 1'b1; tick(); adc_finish = 1'b0;
      chk("s_clr_evt_flag", 32'(protocol_err), 1);
      chk("s_clr_evt_cnt", 32'(err_count), 1);
      tick(); err_clear = 1'b0;
      chk("s_clr_flag", 32'(protocol_err), 0);
      chk("s_clr_cnt", 32'(err_count), 0);
      chk("s_ccnt_kept", 32'(check_count), 5);

      // timeout, with a second check queued behind it
      l1a_trig = 1'b1; tick(); l1a_trig = 1'b0;
      tick();
      chk("to_need", 32'(need_check), 1);
      tick();
      l1a_trig = 1'b1; tick(); l1a_trig = 1'b0;
      repeat (9) tick();
      chk("to_not_yet", 32'(timeout_err), 0);
      chk("to_act_hold", 32'(active_adc), 1);
      chk("to_pend2", 32'(pending), 2);
      tick();
      chk("to_flag", 32'(timeout_err), 1);
      chk("to_errcnt", 32'(err_count), 1);
      chk("to_pend1", 32'(pending), 1);
      chk("to_act0", 32'(active_adc), 0);
      chk("to_no_done", 32'(done), 0);
      chk("to_gap_busy", 32'(busy), 1);
      tick();
      chk("to_idle", 32'({busy, need_check}), 0);
      tick();
      chk("to_next_need", 32'(need_check), 1);
      run_one("after_to");
      chk("to_ccnt", 32'(check_count), 6);
      chk("to_pend0", 32'(pending), 0);

      // finish on the timer==TIMEOUT cycle counts as a finish
      tick();
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      l1a_trig = 1'b1; tick(); l1a_trig = 1'b0;
      tick(); tick();
      adc_finish = 1'b1; tick(); adc_finish = 1'b0;
      repeat (9) tick();
      adc_finish = 1'b1; tick(); adc_finish = 1'b0;
      chk("edge_done", 32'(done), 1);
      chk("edge_no_to", 32'(timeout_err), 0);
      chk("edge_errcnt", 32'(err_count), 0);
      chk("edge_ccnt", 32'(check_count), 7);
      tick();

      // trigger coincident with final finish at full depth
      l1a_trig = 1'b1; repeat (4) tick(); l1a_trig = 1'b0;
      chk("sim_pend4", 32'(pending), 4);
      adc_finish = 1'b1; tick();
      l1a_trig = 1'b1; tick(); l1a_trig = 1'b0; adc_finish = 1'b0;
      chk("sim_done", 32'(done), 1);
      chk("sim_pend", 32'(pending), 4);
      chk("sim_no_ovf", 32'(overflow_err), 0);
      chk("sim_errcnt", 32'(err_count), 0);
      chk("sim_ccnt", 32'(check_count), 8);

      // asynchronous reset in the middle of a check
      run_one("pre_rst");
      wait_in_wait("rst_mid");
      chk("rm_pend3", 32'(pending), 3);
      #2 reset = 1'b0;
      #1;
      chk("rm_busy", 32'(busy), 0);
      chk("rm_pend", 32'(pending), 0);
      chk("rm_act", 32'(active_adc), 0);
      chk("rm_pulses", 32'({need_check, done}), 0);
      chk("rm_flags", 32'({overflow_err, timeout_err, protocol_err}), 0);
      chk("rm_cnts", 32'({err_count, check_count}), 0);
      nc_snap = nc_cnt;
      reset = 1'b1;
      repeat (6) tick();
      chk("rm_no_issue", 32'(nc_cnt), 32'(nc_snap));
      chk("rm_idle", 32'({busy, pending}), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
